// File: rtl/rf80386_pkg.sv
// rf80386_pkg: shared selector/descriptor types and descriptor-loader enums for the rf80386 core.
package rf80386_pkg;

    typedef enum logic [1:0] {
        KIND_CS   = 2'd0,
        KIND_SS   = 2'd1,
        KIND_DATA = 2'd2
    } e_desc_kind;

    typedef enum logic [2:0] {
        FLT_NONE = 3'd0,
        FLT_GP   = 3'd1,
        FLT_NP   = 3'd2,
        FLT_SS   = 3'd3,
        FLT_BUS  = 3'd4
    } e_desc_fault;

    typedef struct packed {
        logic [12:0] ndx;
        logic        ti;
        logic [1:0]  rpl;
    } selector_t;

    typedef struct packed {
        logic [7:0]  base_hi;
        logic        g;
        logic        db;
        logic        l;
        logic        avl;
        logic [3:0]  limit_hi;
        logic        p;
        logic [1:0]  dpl;
        logic        s;
        logic [3:0]  typ;
        logic [23:0] base_lo;
        logic [15:0] limit_lo;
    } desc386_t;

    // Data segments are always readable; code segments only with the R bit.
    function automatic logic fnIsReadableCodeOrData(input logic [3:0] typ);
        return !typ[3] || typ[1];
    endfunction

endpackage

// File: rtl/rf80386_desc_check.sv
// rf80386_desc_check: combinational type/privilege/present checks on a fetched segment descriptor.
module rf80386_desc_check
    import rf80386_pkg::*;
(
    input  logic [63:0] desc_i,
    input  logic [1:0]  kind_i,
    input  logic [1:0]  cpl_i,
    input  logic [1:0]  rpl_i,
    output logic [2:0]  fault_o
);
    desc386_t    d;
    e_desc_fault f;
    logic [1:0]  max_pl;

    assign d       = desc386_t'(desc_i);
    assign max_pl  = (cpl_i > rpl_i) ? cpl_i : rpl_i;
    assign fault_o = f;

    // Priority order matters: the first failing check decides the fault.
    always_comb begin
        f = FLT_NONE;
        if (!d.s)
            f = FLT_GP;
        else if (kind_i == KIND_CS && !d.typ[3])
            f = FLT_GP;
        else if (kind_i == KIND_SS && (d.typ[3] || !d.typ[1] || d.dpl != rpl_i || d.dpl != cpl_i))
            f = FLT_GP;
        else if (kind_i == KIND_DATA && (!fnIsReadableCodeOrData(d.typ) ||
                 ((!d.typ[3] || !d.typ[2]) && d.dpl < max_pl)))
            f = FLT_GP;
        else if (!d.p)
            f = (kind_i == KIND_SS) ? FLT_SS : FLT_NP;
    end

endmodule

// File: rtl/rf80386_desc_loader.sv
// rf80386_desc_loader: GDT/LDT descriptor fetch over Wishbone plus protected-mode load checks.
// Optional accessed-bit write-back (locked RMW) enabled by defining RF80386_DESC_ACCESSED_EN.
module rf80386_desc_loader
    import rf80386_pkg::*;
#(
    parameter int AWID        = 32,
    parameter int TBL_LIMIT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic [15:0]            sel_i,
    input  logic [1:0]             kind_i,
    input  logic [1:0]             cpl_i,
    input  logic [AWID-1:0]        gdt_base_i,
    input  logic [TBL_LIMIT_W-1:0] gdt_limit_i,
    input  logic [AWID-1:0]        ldt_base_i,
    input  logic [TBL_LIMIT_W-1:0] ldt_limit_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   null_o,
    output logic [63:0]            desc_o,
    output logic                   fault_o,
    output logic [2:0]             fault_code_o,
    output logic [15:0]            err_code_o,
    output logic                   cyc_o,
    output logic                   stb_o,
    output logic                   we_o,
    output logic                   lock_o,
    output logic [3:0]             sel_o,
    output logic [AWID-1:0]        adr_o,
    output logic [31:0]            dat_o,
    input  logic [31:0]            dat_i,
    input  logic                   ack_i,
    input  logic                   err_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_RD_LO, S_RD_HI, S_VALIDATE, S_ACC_WR, S_DONE
    } state_t;

    state_t                 state, nxt;
    selector_t              sel_q;
    logic [1:0]             kind_q, cpl_q;
    logic [AWID-1:0]        base_q, adr;
    logic [TBL_LIMIT_W-1:0] limit_q;
    logic [63:0]            desc_q, desc_fin;
    logic [2:0]             chk_code, res_code;
    logic                   set_res, res_null, is_null, over, bus_act;

    rf80386_desc_check u_check (
        .desc_i  (desc_q),
        .kind_i  (kind_q),
        .cpl_i   (cpl_q),
        .rpl_i   (sel_q.rpl),
        .fault_o (chk_code)
    );

    assign is_null = sel_q.ndx == 13'd0 && !sel_q.ti;
    assign over    = TBL_LIMIT_W'({sel_q.ndx, 3'b111}) > limit_q;
    assign adr     = base_q + AWID'({sel_q.ndx, 3'b000}) + ((state == S_RD_LO) ? AWID'(0) : AWID'(4));
    assign bus_act = state == S_RD_LO || state == S_RD_HI || state == S_ACC_WR;

    // Bus controls decode straight from state so an async reset drops them at once.
    assign cyc_o  = bus_act;
    assign stb_o  = bus_act;
    assign adr_o  = bus_act ? adr : '0;
    assign sel_o  = (state == S_RD_LO || state == S_RD_HI) ? 4'hF : (state == S_ACC_WR) ? 4'b0010 : 4'h0;
    assign done_o = state == S_DONE;
    assign busy_o = state != S_IDLE && state != S_DONE;

`ifdef RF80386_DESC_ACCESSED_EN
    assign we_o     = state == S_ACC_WR;
    assign lock_o   = state == S_RD_LO || state == S_RD_HI || state == S_VALIDATE || state == S_ACC_WR;
    assign dat_o    = we_o ? (desc_q[63:32] | 32'h100) : 32'h0;
    assign desc_fin = desc_q | 64'h0000_0100_0000_0000;
`else
    assign we_o     = 1'b0;
    assign lock_o   = 1'b0;
    assign dat_o    = 32'h0;
    assign desc_fin = desc_q;
`endif

    always_comb begin
        nxt      = state;
        set_res  = 1'b0;
        res_code = FLT_NONE;
        res_null = 1'b0;
        case (state)
            S_IDLE: nxt = req_i ? S_CHK : S_IDLE;
            S_CHK: begin
                if (is_null || over) begin
                    nxt      = S_DONE;
                    set_res  = 1'b1;
                    res_null = is_null && kind_q == KIND_DATA;
                    res_code = res_null ? FLT_NONE : FLT_GP;
                end else
                    nxt = S_RD_LO;
            end
            S_RD_LO, S_RD_HI, S_ACC_WR: begin
                if (err_i) begin
                    nxt      = S_DONE;
                    set_res  = 1'b1;
                    res_code = FLT_BUS;
                end else if (ack_i) begin
                    nxt     = (state == S_RD_LO) ? S_RD_HI : (state == S_RD_HI) ? S_VALIDATE : S_DONE;
                    set_res = state == S_ACC_WR;
                end
            end
            S_VALIDATE: begin
                res_code = chk_code;
`ifdef RF80386_DESC_ACCESSED_EN
                nxt     = (chk_code == FLT_NONE && !desc_q[40]) ? S_ACC_WR : S_DONE;
                set_res = nxt == S_DONE;
`else
                nxt     = S_DONE;
                set_res = 1'b1;
`endif
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            sel_q        <= '0;
            kind_q       <= '0;
            cpl_q        <= '0;
            base_q       <= '0;
            limit_q      <= '0;
            desc_q       <= '0;
            null_o       <= 1'b0;
            desc_o       <= '0;
            fault_o      <= 1'b0;
            fault_code_o <= '0;
            err_code_o   <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && req_i) begin
                sel_q   <= selector_t'(sel_i);
                kind_q  <= kind_i;
                cpl_q   <= cpl_i;
                base_q  <= sel_i[2] ? ldt_base_i : gdt_base_i;
                limit_q <= sel_i[2] ? ldt_limit_i : gdt_limit_i;
            end
            if (state == S_RD_LO && ack_i && !err_i)
                desc_q[31:0] <= dat_i;
            if (state == S_RD_HI && ack_i && !err_i)
                desc_q[63:32] <= dat_i;
            if (set_res) begin
                null_o       <= res_null;
                desc_o       <= res_null ? 64'h0 : desc_fin;
                fault_o      <= res_code != FLT_NONE;
                fault_code_o <= res_code;
                err_code_o   <= {sel_q[15:2], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_rf80386_desc_loader.sv
// tb_rf80386_desc_loader: directed-vector bench with a zero-wait Wishbone slave holding one descriptor.
module tb_rf80386_desc_loader;
`ifdef RF80386_DESC_ACCESSED_EN
    localparam int ACC = 1;
`else
    localparam int ACC = 0;
`endif
    localparam logic [63:0] ABIT = (ACC != 0) ? 64'h0000_0100_0000_0000 : 64'h0;

    logic        clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0;
    logic [15:0] sel_i = '0;
    logic [1:0]  kind_i = '0, cpl_i = '0;
    logic [31:0] gdt_base_i = 32'h1000, gdt_limit_i = 32'h3F, ldt_base_i = 32'h2000, ldt_limit_i = 32'h17;
    logic        busy_o, done_o, null_o, fault_o, cyc_o, stb_o, we_o, lock_o, ack_i, err_i;
    logic [63:0] desc_o;
    logic [2:0]  fault_code_o;
    logic [15:0] err_code_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o, dat_i;

    logic [31:0] m_lo = 32'h0000FFFF, m_hi = 32'h00CF9200;
    logic        ack_en = 1'b1, err_hi = 1'b0;
    logic [31:0] prev_rd = '0, last_rd = '0, wr_adr = '0, wr_dat = '0;
    logic [3:0]  wr_sel = '0;
    int          n_ack = 0, n_wr = 0, lock_bad = 0;
    int          checks = 0, errors = 0, n, a0, w0;
    logic        busy1;

    rf80386_desc_loader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .sel_i(sel_i), .kind_i(kind_i), .cpl_i(cpl_i),
        .gdt_base_i(gdt_base_i), .gdt_limit_i(gdt_limit_i), .ldt_base_i(ldt_base_i), .ldt_limit_i(ldt_limit_i),
        .busy_o(busy_o), .done_o(done_o), .null_o(null_o), .desc_o(desc_o), .fault_o(fault_o),
        .fault_code_o(fault_code_o), .err_code_o(err_code_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .lock_o(lock_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    assign err_i = cyc_o & stb_o & err_hi & ~we_o & adr_o[2];
    assign ack_i = cyc_o & stb_o & ack_en & ~err_i;
    assign dat_i = adr_o[2] ? m_hi : m_lo;

    always @(posedge clk_i) begin
        if (cyc_o && ack_i) begin
            n_ack <= n_ack + 1;
            if (we_o) begin
                n_wr   <= n_wr + 1;
                wr_adr <= adr_o;
                wr_dat <= dat_o;
                wr_sel <= sel_o;
            end else begin
                prev_rd <= last_rd;
                last_rd <= adr_o;
            end
        end
    end

    always @(negedge clk_i)
        if (cyc_o && lock_o != ACC[0])
            lock_bad <= lock_bad + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and return the cycle (edge 0 = acceptance) in which done_o is seen.
    task automatic run(input logic [15:0] s, input logic [1:0] k, input logic [1:0] c, output int cyc);
        @(negedge clk_i);
        sel_i = s; kind_i = k; cpl_i = c; req_i = 1'b1;
        a0 = n_ack; w0 = n_wr;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1) busy1 = busy_o;
        end while (!done_o && cyc < 20);
        check("done_seen", done_o, 1);
    endtask

    task automatic expect_fault(input string tag, input int cyc, input logic [2:0] code, input logic [15:0] err);
        check({tag, "_cycle"}, n, cyc);
        check({tag, "_fault"}, fault_o, 1);
        check({tag, "_code"}, fault_code_o, code);
        check({tag, "_err"}, err_code_o, err);
    endtask

    initial begin
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cyc", cyc_o, 0);
        check("rst_desc", desc_o, 0);
        check("rst_fault", fault_o, 0);
        @(negedge clk_i) rst_ni = 1'b1;

        // Flat 4 GiB data segment from the GDT
        run(16'h0010, 2'd2, 2'd0, n);
        check("data_cycle", n, 5 + ACC);
        check("data_busy", busy1, 1);
        check("data_desc", desc_o, 64'h00CF92000000FFFF | ABIT);
        check("data_fault", fault_o, 0);
        check("data_null", null_o, 0);
        check("data_rd_lo", prev_rd, 32'h1010);
        check("data_rd_hi", last_rd, 32'h1014);
        check("data_writes", n_wr - w0, ACC);
        check("data_cyc_done", cyc_o, 0);
`ifdef RF80386_DESC_ACCESSED_EN
        check("acc_wr_adr", wr_adr, 32'h1014);
        check("acc_wr_sel", wr_sel, 4'b0010);
        check("acc_wr_dat", wr_dat, 32'h00CF9300);
`endif
        @(negedge clk_i);
        check("hold_desc", desc_o, 64'h00CF92000000FFFF | ABIT);

        run(16'h0040, 2'd2, 2'd0, n);
        expect_fault("limit", 2, 3'd1, 16'h0040);
        check("limit_nobus", n_ack - a0, 0);

        run(16'h0000, 2'd1, 2'd0, n);
        expect_fault("null_ss", 2, 3'd1, 16'h0000);
        run(16'h0000, 2'd2, 2'd0, n);
        check("null_ds_null", null_o, 1);
        check("null_ds_fault", fault_o, 0);
        check("null_ds_desc", desc_o, 0);

        m_hi = 32'h00CFF200;
        run(16'h0010, 2'd1, 2'd0, n);
        expect_fault("ss_dpl", 5, 3'd1, 16'h0010);
        m_hi = 32'h00CF1200;
        run(16'h0010, 2'd1, 2'd0, n);
        expect_fault("ss_np", 5, 3'd3, 16'h0010);
        run(16'h0010, 2'd2, 2'd0, n);
        expect_fault("ds_np", 5, 3'd2, 16'h0010);

        m_hi = 32'h00CF9200;
        run(16'h0010, 2'd0, 2'd0, n);
        expect_fault("cs_data", 5, 3'd1, 16'h0010);
        m_hi = 32'h00CF9A00;
        run(16'h0010, 2'd0, 2'd0, n);
        check("cs_ok_fault", fault_o, 0);
        check("cs_ok_desc", desc_o, 64'h00CF9A000000FFFF | ABIT);

        m_hi = 32'h00CF9800;
        run(16'h0010, 2'd2, 2'd0, n);
        expect_fault("ds_xonly", 5, 3'd1, 16'h0010);
        m_hi = 32'h00CF8200;
        run(16'h0010, 2'd2, 2'd0, n);
        expect_fault("ds_sys", 5, 3'd1, 16'h0010);
        m_hi = 32'h00CF9200;
        run(16'h0013, 2'd2, 2'd3, n);
        expect_fault("ds_priv", 5, 3'd1, 16'h0010);
        m_hi = 32'h00CF9E00;
        run(16'h0013, 2'd2, 2'd3, n);
        check("conf_fault", fault_o, 0);
        check("conf_desc", desc_o, 64'h00CF9E000000FFFF | ABIT);

        // LDT at its exact limit, then one byte short
        m_hi = 32'h00CF9200;
        run(16'h0014, 2'd2, 2'd0, n);
        check("ldt_fault", fault_o, 0);
        check("ldt_rd_lo", prev_rd, 32'h2010);
        check("ldt_rd_hi", last_rd, 32'h2014);
        ldt_limit_i = 32'h16;
        run(16'h0014, 2'd2, 2'd0, n);
        expect_fault("ldt_limit", 2, 3'd1, 16'h0014);

        gdt_base_i = 32'hFFFF_FFF8;
        run(16'h0008, 2'd2, 2'd0, n);
        check("wrap_rd_lo", prev_rd, 32'h0);
        check("wrap_rd_hi", last_rd, 32'h4);
        gdt_base_i = 32'h1000;

        err_hi = 1'b1;
        run(16'h0010, 2'd2, 2'd0, n);
        expect_fault("bus_err", 4, 3'd4, 16'h0010);
        check("bus_err_cyc", cyc_o, 0);
        err_hi = 1'b0;

        check("lock_track", lock_bad, 0);

        // Reset while the low-dword read is stalled
        ack_en = 1'b0;
        @(negedge clk_i);
        sel_i = 16'h0010; kind_i = 2'd2; cpl_i = 2'd0; req_i = 1'b1;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_mid_cyc_pre", cyc_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        check("rst_mid_cyc", cyc_o, 0);
        check("rst_mid_stb", stb_o, 0);
        check("rst_mid_busy", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        ack_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
